// File: rtl/mod_decomp_balanced_pkg.sv
// Shared types for the balanced gadget decomposer: FSM state encoding and
// the decomposition geometry (base width, digit count).
package mod_decomp_balanced_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } dec_state_e;

    typedef struct packed {
        int unsigned base_w;
        int unsigned level;
    } decomp_cfg_t;

    // Number of low coefficient bits that are rounded away before digit extraction.
    function automatic int drop_bits(input int mod_w, input decomp_cfg_t cfg);
        return mod_w - int'(cfg.base_w * cfg.level);
    endfunction

endpackage

// File: rtl/mod_decomp_balanced_if.sv
// Coefficient-in / digit-out stream bundle. The master drives coefficients
// and output ready; the slave (decomposer) answers with ready and digits.
interface mod_decomp_balanced_if #(
    parameter int MOD_W  = 33,
    parameter int BASE_W = 4,
    parameter int SIDE_W = 0
);
    localparam int SW = (SIDE_W > 0) ? SIDE_W : 1;

    logic [MOD_W-1:0]  in_a;
    logic [SW-1:0]     in_side;
    logic              in_avail;
    logic              in_rdy;
    logic [BASE_W-1:0] out_digit;
    logic [SW-1:0]     out_side;
    logic              out_last;
    logic              out_avail;
    logic              out_rdy;

    modport master (
        output in_a, in_side, in_avail, out_rdy,
        input  in_rdy, out_digit, out_side, out_last, out_avail
    );

    modport slave (
        input  in_a, in_side, in_avail, out_rdy,
        output in_rdy, out_digit, out_side, out_last, out_avail
    );

endinterface

// File: rtl/mod_decomp_balanced_digit.sv
// One balanced digit step: adds the incoming carry to a BASE_W-bit slice and
// folds values at or above half the base into the negative range.
module mod_decomp_balanced_digit #(
    parameter int BASE_W = 4
) (
    input  logic [BASE_W-1:0] slice_i,
    input  logic              carry_i,
    output logic [BASE_W-1:0] digit_o,
    output logic              carry_o
);
    localparam logic [BASE_W:0] HALF = (BASE_W+1)'(1) << (BASE_W - 1);

    logic [BASE_W:0] v;

    assign v = {1'b0, slice_i} + {{BASE_W{1'b0}}, carry_i};
    // Subtracting 2^BASE_W leaves the low bits untouched in two's complement.
    assign digit_o = v[BASE_W-1:0];
    assign carry_o = (v >= HALF);

endmodule

// File: rtl/mod_decomp_balanced.sv
// Signed balanced gadget decomposition: rounds a coefficient to LEVEL*BASE_W
// bits and streams LEVEL balanced digits, least-significant first.
module mod_decomp_balanced
    import mod_decomp_balanced_pkg::*;
#(
    parameter int         MOD_W    = 33,
    parameter int         BASE_W   = 4,
    parameter int         LEVEL    = 3,
    parameter int         SIDE_W   = 0,
    parameter logic [1:0] RST_SIDE = 2'b00
) (
    input  logic                  clk,
    input  logic                  s_rst,
    mod_decomp_balanced_if.slave  bus
);
    localparam decomp_cfg_t CFG = '{base_w: BASE_W, level: LEVEL};
    localparam int S_RAW = drop_bits(MOD_W, CFG);
    localparam int S     = (S_RAW > 0) ? S_RAW : 0;
    localparam int RW    = MOD_W - S;
    localparam int CNT_W = (LEVEL > 1) ? $clog2(LEVEL) : 1;
    localparam int SW    = (SIDE_W > 0) ? SIDE_W : 1;

    if (BASE_W < 2 || BASE_W > 16) begin : g_bad_base
        $fatal(1, "mod_decomp_balanced: BASE_W=%0d outside 2..16", BASE_W);
    end
    if (LEVEL < 1 || S_RAW < 0) begin : g_bad_level
        $fatal(1, "mod_decomp_balanced: LEVEL*BASE_W=%0d exceeds MOD_W=%0d", LEVEL * BASE_W, MOD_W);
    end

    dec_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RW-1:0]     rem_q, rem_d;
    logic              carry_q, carry_d;
    logic [BASE_W-1:0] digit_q, digit_d;
    logic [SW-1:0]     side_q;

    logic [RW-1:0]     r_round;
    logic [BASE_W-1:0] slice;
    logic              cin;
    logic [BASE_W-1:0] dig;
    logic              cout;
    logic              is_last;
    logic              out_avail;
    logic              out_last;
    logic              in_rdy;
    logic              accept;
    logic              out_xfer;

    // Round to nearest at bit S; the overflow out of RW bits wraps away.
    if (S > 0) begin : g_round
        assign r_round = bus.in_a[MOD_W-1:S] + RW'(bus.in_a[S-1]);
    end else begin : g_noround
        assign r_round = bus.in_a;
    end

    assign is_last  = (cnt_q == CNT_W'(LEVEL - 1));
    assign accept   = bus.in_avail && in_rdy;
    assign out_xfer = out_avail && bus.out_rdy;

    // The new coefficient's digit 0 and the running digits share one step unit.
    assign slice = accept ? r_round[BASE_W-1:0] : rem_q[BASE_W-1:0];
    assign cin   = accept ? 1'b0 : carry_q;

    mod_decomp_balanced_digit #(.BASE_W(BASE_W)) u_digit (
        .slice_i (slice),
        .carry_i (cin),
        .digit_o (dig),
        .carry_o (cout)
    );

    always_ff @(posedge clk) begin
        if (s_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            carry_q <= 1'b0;
            digit_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            carry_q <= carry_d;
            digit_q <= digit_d;
        end
    end

    always_ff @(posedge clk) begin
        if (s_rst && RST_SIDE[0]) begin
            side_q <= '0;
        end else if (s_rst && RST_SIDE[1]) begin
            side_q <= '1;
        end else if (accept) begin
            side_q <= bus.in_side;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_RUN;
            ST_RUN:  if (out_xfer && is_last && !accept) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        carry_d = carry_q;
        digit_d = digit_q;
        if (accept) begin
            cnt_d   = '0;
            rem_d   = r_round >> BASE_W;
            carry_d = cout;
            digit_d = dig;
        end else if (out_xfer && !is_last) begin
            cnt_d   = cnt_q + CNT_W'(1);
            rem_d   = rem_q >> BASE_W;
            carry_d = cout;
            digit_d = dig;
        end
    end

    always_comb begin
        out_avail = (state_q == ST_RUN);
        out_last  = (state_q == ST_RUN) && is_last;
        in_rdy    = !s_rst && ((state_q == ST_IDLE) || (bus.out_rdy && out_last));
    end

    assign bus.out_avail = out_avail;
    assign bus.out_last  = out_last;
    assign bus.in_rdy    = in_rdy;
    assign bus.out_digit = digit_q;
    assign bus.out_side  = side_q;

endmodule

// File: tb/tb_mod_decomp_balanced.sv
// Bench for mod_decomp_balanced at MOD_W=12, BASE_W=4, LEVEL=2, side data on.
module tb_mod_decomp_balanced;
    import mod_decomp_balanced_pkg::*;

    localparam int MOD_W  = 12;
    localparam int BASE_W = 4;
    localparam int LEVEL  = 2;
    localparam int SIDE_W = 4;
    localparam int S      = MOD_W - LEVEL * BASE_W;
    localparam longint MODV = 64'd1 << MOD_W;

    typedef logic [BASE_W-1:0] nib_t;
    typedef nib_t nib_arr_t [LEVEL];
    typedef logic bit_arr_t [LEVEL];
    typedef int   int_arr_t [LEVEL];

    logic clk;
    logic s_rst;
    int   checks;
    int   failures;

    mod_decomp_balanced_if #(.MOD_W(MOD_W), .BASE_W(BASE_W), .SIDE_W(SIDE_W)) bus ();

    mod_decomp_balanced #(
        .MOD_W(MOD_W), .BASE_W(BASE_W), .LEVEL(LEVEL),
        .SIDE_W(SIDE_W), .RST_SIDE(2'b01)
    ) dut (
        .clk   (clk),
        .s_rst (s_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Balanced radix-2^BASE_W expansion of the rounded value via centred remainders.
    function automatic int_arr_t model_digits(input longint a);
        int_arr_t d;
        longint   r;
        longint   x;
        longint   rem;
        longint   base;
        base = 64'd1 << BASE_W;
        r = (S > 0) ? ((a + (64'd1 << (S - 1))) >> S) : a;
        x = r % (64'd1 << (LEVEL * BASE_W));
        for (int j = 0; j < LEVEL; j++) begin
            rem = x % base;
            d[j] = (rem >= base / 2) ? int'(rem - base) : int'(rem);
            x = (x - longint'(d[j])) / base;
        end
        return d;
    endfunction

    function automatic longint rounded_value(input longint a);
        longint half;
        half = (S > 0) ? (64'd1 << (S - 1)) : 64'd0;
        return (((a + half) >> S) << S) % MODV;
    endfunction

    function automatic longint recompose(input nib_arr_t dg);
        longint sum;
        sum = 0;
        for (int j = 0; j < LEVEL; j++)
            sum += longint'(int'($signed(dg[j]))) * (64'd1 << (S + j * BASE_W));
        return ((sum % MODV) + MODV) % MODV;
    endfunction

    // Pushes one coefficient and collects its digits with out_rdy held high.
    task automatic do_coef(input logic [MOD_W-1:0] a, input logic [SIDE_W-1:0] side,
                           output nib_arr_t dg, output bit_arr_t lst, output nib_arr_t sd,
                           output int lat, output bit ok);
        int   n;
        logic acc;
        logic av;
        ok  = 1'b1;
        lat = 0;
        dg  = '{default: '0};
        sd  = '{default: '0};
        lst = '{default: 1'b0};
        bus.in_a     = a;
        bus.in_side  = side;
        bus.in_avail = 1'b1;
        bus.out_rdy  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            acc = bus.in_rdy;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 20);
        bus.in_avail = 1'b0;
        if (!acc) begin
            ok = 1'b0;
            return;
        end
        for (int k = 0; k < LEVEL; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                av = bus.out_avail;
                n++;
                if (!av) begin
                    @(posedge clk); #1;
                end
            end while (!av && n < 20);
            if (!av) begin
                ok = 1'b0;
                return;
            end
            if (k == 0) lat = n;
            dg[k]  = bus.out_digit;
            lst[k] = bus.out_last;
            sd[k]  = bus.out_side;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        s_rst        = 1'b1;
        bus.in_a     = '0;
        bus.in_side  = '0;
        bus.in_avail = 1'b1;
        bus.out_rdy  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checks++; if (bus.in_rdy !== 1'b0) begin failures++; $display("FAIL rst_in_rdy got=%b want=0", bus.in_rdy); end
        checks++; if (bus.out_avail !== 1'b0) begin failures++; $display("FAIL rst_out_avail got=%b want=0", bus.out_avail); end
        checks++; if (bus.out_last !== 1'b0) begin failures++; $display("FAIL rst_out_last got=%b want=0", bus.out_last); end
        checks++; if (bus.out_digit !== 4'h0) begin failures++; $display("FAIL rst_out_digit got=%h want=0", bus.out_digit); end
        checks++; if (bus.out_side !== 4'h0) begin failures++; $display("FAIL rst_out_side got=%h want=0", bus.out_side); end
        @(posedge clk); #1;
        s_rst        = 1'b0;
        bus.in_avail = 1'b0;
        @(negedge clk);
        checks++; if (bus.in_rdy !== 1'b1) begin failures++; $display("FAIL post_rst_in_rdy got=%b want=1", bus.in_rdy); end
        checks++; if (bus.out_avail !== 1'b0) begin failures++; $display("FAIL post_rst_out_avail got=%b want=0", bus.out_avail); end
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [MOD_W-1:0] va [4] = '{12'h123, 12'h0C0, 12'h7F8, 12'hFF8};
        int               e0 [4] = '{2, -4, 0, 0};
        int               e1 [4] = '{1, 1, -8, 0};
        longint           er [4] = '{64'h120, 64'h0C0, 64'h800, 64'h000};
        nib_arr_t dg;
        nib_arr_t sd;
        bit_arr_t lst;
        int       lat;
        bit       ok;
        for (int i = 0; i < 4; i++) begin
            do_coef(va[i], SIDE_W'(i + 3), dg, lst, sd, lat, ok);
            checks++; if (!ok) begin failures++; $display("FAIL dir_timeout a=%h got=timeout want=digits", va[i]); continue; end
            checks++; if (int'($signed(dg[0])) != e0[i]) begin failures++; $display("FAIL dir_d0 a=%h got=%0d want=%0d", va[i], $signed(dg[0]), e0[i]); end
            checks++; if (int'($signed(dg[1])) != e1[i]) begin failures++; $display("FAIL dir_d1 a=%h got=%0d want=%0d", va[i], $signed(dg[1]), e1[i]); end
            checks++; if (lst[0] !== 1'b0 || lst[1] !== 1'b1) begin failures++; $display("FAIL dir_last a=%h got=%b%b want=01", va[i], lst[0], lst[1]); end
            checks++; if (lat != 1) begin failures++; $display("FAIL dir_latency a=%h got=%0d want=1", va[i], lat); end
            checks++; if (sd[0] !== SIDE_W'(i + 3) || sd[1] !== SIDE_W'(i + 3)) begin failures++; $display("FAIL dir_side a=%h got=%h/%h want=%h", va[i], sd[0], sd[1], i + 3); end
            checks++; if (recompose(dg) != er[i]) begin failures++; $display("FAIL dir_recomp a=%h got=%h want=%h", va[i], recompose(dg), er[i]); end
        end
    endtask

    task automatic test_random();
        nib_arr_t         dg;
        nib_arr_t         sd;
        bit_arr_t         lst;
        int_arr_t         exp_d;
        int               lat;
        bit               ok;
        logic [MOD_W-1:0] a;
        logic [SIDE_W-1:0] side;
        for (int i = 0; i < 40; i++) begin
            case (i)
                0:       a = 12'hFFF;
                1:       a = 12'h007;
                2:       a = 12'h008;
                3:       a = 12'h778;
                default: a = MOD_W'($urandom_range(0, 4095));
            endcase
            side  = SIDE_W'($urandom_range(0, 15));
            exp_d = model_digits(longint'(a));
            do_coef(a, side, dg, lst, sd, lat, ok);
            checks++; if (!ok) begin failures++; $display("FAIL rnd_timeout a=%h got=timeout want=digits", a); continue; end
            for (int j = 0; j < LEVEL; j++) begin
                checks++; if (int'($signed(dg[j])) != exp_d[j]) begin failures++; $display("FAIL rnd_digit a=%h j=%0d got=%0d want=%0d", a, j, $signed(dg[j]), exp_d[j]); end
            end
            checks++; if (recompose(dg) != rounded_value(longint'(a))) begin failures++; $display("FAIL rnd_recomp a=%h got=%h want=%h", a, recompose(dg), rounded_value(longint'(a))); end
            checks++; if (sd[LEVEL-1] !== side) begin failures++; $display("FAIL rnd_side a=%h got=%h want=%h", a, sd[LEVEL-1], side); end
        end
    endtask

    task automatic test_back_to_back(input int stall);
        nib_t exp_d [4] = '{4'h2, 4'h1, 4'hC, 4'h1};
        logic exp_l [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        nib_t exp_s [4] = '{4'h5, 4'h5, 4'hA, 4'hA};
        bus.in_a     = 12'h123;
        bus.in_side  = 4'h5;
        bus.in_avail = 1'b1;
        bus.out_rdy  = 1'b1;
        @(negedge clk);
        checks++; if (bus.in_rdy !== 1'b1) begin failures++; $display("FAIL b2b_idle_rdy stall=%0d got=%b want=1", stall, bus.in_rdy); end
        @(posedge clk); #1;
        bus.in_a    = 12'h0C0;
        bus.in_side = 4'hA;
        if (stall > 0) begin
            bus.out_rdy = 1'b0;
            for (int c = 0; c < stall; c++) begin
                @(negedge clk);
                checks++; if (bus.out_avail !== 1'b1) begin failures++; $display("FAIL stall_avail c=%0d got=%b want=1", c, bus.out_avail); end
                checks++; if (bus.out_digit !== 4'h2) begin failures++; $display("FAIL stall_digit c=%0d got=%h want=2", c, bus.out_digit); end
                checks++; if (bus.out_side !== 4'h5) begin failures++; $display("FAIL stall_side c=%0d got=%h want=5", c, bus.out_side); end
                checks++; if (bus.out_last !== 1'b0) begin failures++; $display("FAIL stall_last c=%0d got=%b want=0", c, bus.out_last); end
                checks++; if (bus.in_rdy !== 1'b0) begin failures++; $display("FAIL stall_in_rdy c=%0d got=%b want=0", c, bus.in_rdy); end
                @(posedge clk); #1;
            end
            bus.out_rdy = 1'b1;
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (bus.out_avail !== 1'b1) begin failures++; $display("FAIL b2b_avail k=%0d got=%b want=1", k, bus.out_avail); end
            checks++; if (bus.out_digit !== exp_d[k]) begin failures++; $display("FAIL b2b_digit k=%0d got=%h want=%h", k, bus.out_digit, exp_d[k]); end
            checks++; if (bus.out_last !== exp_l[k]) begin failures++; $display("FAIL b2b_last k=%0d got=%b want=%b", k, bus.out_last, exp_l[k]); end
            checks++; if (bus.in_rdy !== exp_l[k]) begin failures++; $display("FAIL b2b_in_rdy k=%0d got=%b want=%b", k, bus.in_rdy, exp_l[k]); end
            checks++; if (bus.out_side !== exp_s[k]) begin failures++; $display("FAIL b2b_side k=%0d got=%h want=%h", k, bus.out_side, exp_s[k]); end
            @(posedge clk); #1;
            if (k == 1) bus.in_avail = 1'b0;
        end
        @(negedge clk);
        checks++; if (bus.out_avail !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b want=0", bus.out_avail); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        nib_arr_t dg;
        nib_arr_t sd;
        bit_arr_t lst;
        int       lat;
        bit       ok;
        bus.in_a     = 12'h0C0;
        bus.in_side  = 4'h9;
        bus.in_avail = 1'b1;
        bus.out_rdy  = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        bus.in_avail = 1'b0;
        @(negedge clk);
        checks++; if (bus.out_digit !== 4'hC) begin failures++; $display("FAIL mid_d0 got=%h want=c", bus.out_digit); end
        @(posedge clk); #1;
        s_rst       = 1'b1;
        bus.out_rdy = 1'b0;
        @(negedge clk);
        checks++; if (bus.in_rdy !== 1'b0) begin failures++; $display("FAIL mid_rst_in_rdy got=%b want=0", bus.in_rdy); end
        @(posedge clk); #1;
        s_rst       = 1'b0;
        bus.out_rdy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (bus.out_avail !== 1'b0) begin failures++; $display("FAIL mid_no_residual c=%0d got=%b want=0", c, bus.out_avail); end
            checks++; if (bus.out_digit !== 4'h0 || bus.out_last !== 1'b0) begin failures++; $display("FAIL mid_cleared c=%0d got=%h/%b want=0/0", c, bus.out_digit, bus.out_last); end
            checks++; if (bus.out_side !== 4'h0) begin failures++; $display("FAIL mid_side c=%0d got=%h want=0", c, bus.out_side); end
            @(posedge clk); #1;
        end
        do_coef(12'h123, 4'h6, dg, lst, sd, lat, ok);
        checks++; if (!ok) begin failures++; $display("FAIL mid_after_timeout got=timeout want=digits"); end
        else begin
            checks++; if (dg[0] !== 4'h2 || dg[1] !== 4'h1) begin failures++; $display("FAIL mid_after_digits got=%h,%h want=2,1", dg[0], dg[1]); end
            checks++; if (lat != 1) begin failures++; $display("FAIL mid_after_latency got=%0d want=1", lat); end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_directed();
        test_back_to_back(0);
        test_back_to_back(3);
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "bench time limit");
    end

endmodule

// File: doc/mod_decomp_balanced.md
Name: mod_decomp_balanced

Overview:
- Signed balanced gadget decomposition of a MOD_W-bit coefficient in the 2^MOD_W domain.
- Produces LEVEL signed digits of BASE_W bits, least-significant first, one digit per cycle on a valid/ready stream.
- It is the inverse path of the recomposition + mod_reduct flow: recompose sum(d_j * 2^(S + j*BASE_W)) mod 2^MOD_W, where S = MOD_W - LEVEL*BASE_W.
- Sits between the key-switch/blind-rotation coefficient source and the external-product multipliers.

Parameters:
- MOD_W, 33, coefficient width; the modulus is 2^MOD_W.
- BASE_W, 4, decomposition base log2. Legal range: 2 to 16.
- LEVEL, 3, number of digits. LEVEL*BASE_W <= MOD_W is required; any violation is a $fatal at elaboration.
- SIDE_W, 0, width of the side data carried with the coefficient. Set to 0 when unused.
- RST_SIDE, 2'b00, side register reset: [0]=1 resets side data to 0; [1]=1 resets it to all-1.

Ports:
- clk  in  1  clock
- s_rst  in  1  synchronous reset, active-high
- in_a  in  MOD_W  coefficient, value in [0, 2^MOD_W)
- in_side  in  SIDE_W  side data, captured together with in_a
- in_avail  in  1  input valid
- in_rdy  out  1  input ready
- out_digit  out  BASE_W  signed digit, two's complement
- out_side  out  SIDE_W  side data of the coefficient being emitted, stable for all of its digits
- out_last  out  1  high on digit LEVEL-1
- out_avail  out  1  output valid
- out_rdy  in  1  output ready

Behaviour:
- Define S = MOD_W - LEVEL*BASE_W and H = 2^(BASE_W-1).
- Input transfer occurs when in_avail && in_rdy. Output transfer occurs when out_avail && out_rdy.
- Rounding on acceptance:
  - r = (in_a >> S) + (S>0 ? in_a[S-1] : 0).
  - r is kept modulo 2^(LEVEL*BASE_W); the rounding overflow bit is dropped.
- Digit j, with carry c (c=0 for j=0):
  - v = r[j*BASE_W +: BASE_W] + c.
  - If v >= H: d_j = v - 2^BASE_W and the next carry is 1.
  - Otherwise: d_j = v and the next carry is 0.
  - The carry out of digit LEVEL-1 is discarded (wrap modulo 2^MOD_W).
  - Digit range is [-H, H-1].
- Datapath: remaining-value register, carry flag, digit counter cnt in [0, LEVEL-1].
- FSM states: IDLE, RUN.
  - IDLE: in_rdy=1, out_avail=0. On an input transfer, go to RUN and load the registered digit 0 (cnt=0).
  - RUN: out_avail=1, out_digit=d_cnt, out_last=(cnt==LEVEL-1).
    - Transfer with cnt<LEVEL-1: cnt increments and the next digit is registered.
    - Transfer on the last digit: return to IDLE.
    - Exception: if in_avail is also high on that last-digit transfer, accept the new coefficient in the same cycle and stay in RUN with cnt=0 (back-to-back).
- in_rdy = (state==IDLE) || (out_rdy && out_last). It is combinational and depends on out_rdy.
- Latency: first digit is valid 1 cycle after the input transfer.
- Throughput: one coefficient per LEVEL cycles with no bubble.
- Backpressure: while out_rdy=0, out_digit, out_last and out_side are held stable, and in_rdy=0 in RUN.
- Reset:
  - During and after s_rst: state=IDLE, cnt=0, out_avail=0, out_last=0, out_digit=0, carry=0.
  - in_rdy=0 while s_rst=1.
  - Side register follows RST_SIDE.
  - A reset mid-coefficient aborts it; no residual digits are emitted.
- Side data is captured with in_a and not altered.

Decomposition:
- common_definition_pkg: add a decomposition parameter struct (BASE_W, LEVEL) and the FSM state enum type.
- One sub-module, mod_decomp_digit: combinational (v, carry) computation from a BASE_W-bit slice and carry-in. It is instantiated once and reused each cycle.

Test Plan (MOD_W=12, BASE_W=4, LEVEL=2, S=4):
- in_a=0x123 -> r=0x12; digits d0=+2, d1=+1 (out_last on d1); first digit 1 cycle after accept.
- in_a=0x0C0 -> r=0x0C; d0=-4 (0xC), carry -> d1=+1; recomposition 256-64=0xC0.
- in_a=0x7F8 -> rounding gives r=0x80; d0=0, d1=-8 (0x8), top carry dropped; recomposes to 0x800.
- in_a=0xFF8 -> rounding overflow wraps r=0x00; d0=0, d1=0.
- Back-to-back stream 0x123, 0x0C0 with out_rdy=1 -> digits 2,1,-4,1 on consecutive cycles, in_rdy high on each last-digit cycle. Same stream with out_rdy low 3 cycles on d0 -> digit and side held, in_rdy=0.
- s_rst pulsed after d0 of 0x0C0 is emitted -> out_avail=0 next cycle, no d1 emitted; next input 0x123 decomposes normally.
